key_display_capture: RTL and testbench

- Consumer stage directly downstream of the keypad row-scan FSM.
- On each scanner drive strobe, samples the driven row and column lines, decodes them to a hex key value, and shifts the key into a two-digit history (newest on the right).
- Time-multiplexes the two digits onto a dual common-anode seven-segment display, with a dead-time blanking cycle at each digit switch.

---
 rtl/key_display_capture.sv | 183 ++++++++++++++++++
 tb/tb_key_display_capture.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/key_display_capture.sv
// key_display_capture: samples the keypad scanner's driven row/column on each
// drive strobe, decodes the key into a two-digit hex history, and multiplexes
// both digits onto a dual common-anode seven-segment display with a one-cycle
// blanking gap at every digit switch.
module key_display_capture #(
  parameter int unsigned REFRESH_CNT = 24000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       drive_en,
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic       key_valid,
  output logic       key_err,
  output logic [3:0] digit_lo,
  output logic [3:0] digit_hi,
  output logic [1:0] an,
  output logic [6:0] seg
);

  localparam int unsigned CNT_W = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_RIGHT = 2'b10;
  localparam logic [1:0] AN_LEFT  = 2'b01;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // True when exactly one bit of the 4-bit vector is set.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Position of the set bit in a one-hot 4-bit vector.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Keypad layout: {row index, column index} to hex key value.
  function automatic logic [3:0] key_decode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      4'b11_11: k = 4'hD;
      default:  k = 4'h0;
    endcase
    return k;
  endfunction

  // Hex digit to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_OFF;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  logic             drive_en_d;
  logic [CNT_W-1:0] refresh_cnt;
  logic             sel;
  logic             blank;

  logic       strobe_c;
  logic       key_ok_c;
  logic [3:0] key_code_c;
  logic [1:0] an_next_c;
  logic [6:0] seg_next_c;

  // Rising-edge strobe detect, validity check and key decode.
  always_comb begin
    strobe_c   = 1'b0;
    key_ok_c   = 1'b0;
    key_code_c = 4'h0;
    strobe_c   = drive_en && !drive_en_d;
    key_ok_c   = is_onehot(row) && is_onehot(col);
    key_code_c = key_decode(onehot_idx(row), onehot_idx(col));
  end

  // Edge-detect history, accept/reject pulses and the two-digit shift register.
  // drive_en_d resets high so a strobe already active at reset release is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drive_en_d <= 1'b1;
      key_valid  <= 1'b0;
      key_err    <= 1'b0;
      digit_lo   <= 4'h0;
      digit_hi   <= 4'h0;
    end else begin
      drive_en_d <= drive_en;
      key_valid  <= strobe_c && key_ok_c;
      key_err    <= strobe_c && !key_ok_c;
      if (strobe_c && key_ok_c) begin
        digit_hi <= digit_lo;
        digit_lo <= key_code_c;
      end
    end
  end

  // Refresh sequencer: each wrap switches digit and inserts one blank cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      sel         <= 1'b0;
      blank       <= 1'b1;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      sel         <= ~sel;
      blank       <= 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
      blank       <= 1'b0;
    end
  end

  // Select anode and segment pattern for the current slot.
  always_comb begin
    an_next_c  = AN_OFF;
    seg_next_c = SEG_OFF;
    if (!blank) begin
      if (!sel) begin
        an_next_c  = AN_RIGHT;
        seg_next_c = seg_encode(digit_lo);
      end else begin
        an_next_c  = AN_LEFT;
        seg_next_c = seg_encode(digit_hi);
      end
    end
  end

  // Anode and segments registered together so they always switch in the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= an_next_c;
      seg <= seg_next_c;
    end
  end

endmodule

// File: tb/tb_key_display_capture.sv
// Scoreboard bench for key_display_capture with a 4-cycle refresh slot.
module tb_key_display_capture;

  localparam int unsigned REF = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       drive_en;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic       key_err;
  logic [3:0] digit_lo;
  logic [3:0] digit_hi;
  logic [1:0] an;
  logic [6:0] seg;

  key_display_capture #(.REFRESH_CNT(REF)) dut (
    .clk(clk), .reset(reset), .drive_en(drive_en), .row(row), .col(col),
    .key_valid(key_valid), .key_err(key_err), .digit_lo(digit_lo),
    .digit_hi(digit_hi), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Hand-written active-low segment table indexed by hex digit.
  logic [6:0] enc_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] key_q  [$];
  logic [8:0] disp_q [$];
  logic [3:0] m_lo = 4'h0;
  logic [3:0] m_hi = 4'h0;
  int         k    = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Expected display per edge: slot = 1 blank cycle then REF-1 cycles of one digit.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k = 0;
      disp_q.delete();
    end else begin
      k = k + 1;
      if (((k - 1) % REF) == 0)
        disp_q.push_back({2'b11, 7'b1111111});
      else if ((((k - 1) / REF) % 2) == 0)
        disp_q.push_back({2'b10, enc_tab[m_lo]});
      else
        disp_q.push_back({2'b01, enc_tab[m_hi]});
    end
  end

  // Display monitor.
  always @(negedge clk) begin
    if (!reset && disp_q.size() > 0)
      chk("display", 16'({an, seg}), 16'(disp_q.pop_front()));
  end

  // Key event monitor: every key_valid/key_err cycle must match a queued event.
  always @(negedge clk) begin
    if (!reset && (key_valid || key_err)) begin
      if (key_q.size() == 0)
        chk("key_unexpected", 16'({key_valid, key_err, digit_lo, digit_hi}), 16'h0);
      else
        chk("key_event", 16'({key_valid, key_err, digit_lo, digit_hi}), 16'(key_q.pop_front()));
    end
  end

  task automatic press(input logic [3:0] r, input logic [3:0] c, input int hold,
                       input bit ok, input logic [3:0] v);
    row = r; col = c; drive_en = 1'b1;
    if (ok) key_q.push_back({1'b1, 1'b0, v, m_lo});
    else    key_q.push_back({1'b0, 1'b1, m_lo, m_hi});
    @(posedge clk); #1;
    if (ok) begin m_hi = m_lo; m_lo = v; end
    for (int i = 1; i < hold; i++) begin @(posedge clk); #1; end
    drive_en = 1'b0; row = 4'h0; col = 4'h0;
    @(posedge clk); #1;
    chk("key_pending", 16'(key_q.size()), 16'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input bit hold_strobe);
    @(negedge clk);
    if (hold_strobe) begin row = 4'b0001; col = 4'b0001; drive_en = 1'b1; end
    #2; reset = 1'b1; #1;
    chk("rst_an",     16'(an),  16'h3);
    chk("rst_seg",    16'(seg), 16'h7f);
    chk("rst_digits", 16'({digit_hi, digit_lo}), 16'h0);
    chk("rst_pulses", 16'({key_valid, key_err}), 16'h0);
    key_q.delete();
    m_lo = 4'h0; m_hi = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    if (hold_strobe) begin
      idle(4);
      drive_en = 1'b0; row = 4'h0; col = 4'h0;
    end
  endtask

  initial begin
    reset = 1'b1; drive_en = 1'b0; row = 4'h0; col = 4'h0;
    do_reset(1'b0);
    idle(7);
    // single key r0c1 -> 2
    press(4'b0001, 4'b0010, 1, 1'b1, 4'h2);
    idle(8);
    // r2c0 -> 7, then r3c1 -> 0
    press(4'b0100, 4'b0001, 1, 1'b1, 4'h7);
    press(4'b1000, 4'b0010, 1, 1'b1, 4'h0);
    idle(10);
    // held strobe r3c2 -> F, exactly one capture
    press(4'b1000, 4'b0100, 5, 1'b1, 4'hF);
    // rejected strobes
    press(4'b0001, 4'b0110, 1, 1'b0, 4'h0);
    press(4'b0000, 4'b0001, 1, 1'b0, 4'h0);
    press(4'b0011, 4'b0001, 1, 1'b0, 4'h0);
    idle(5);
    // capture whose update edge coincides with a refresh wrap: r1c3 -> B
    for (int i = 0; i < 2 * REF && (k % REF) != REF - 1; i++) begin @(posedge clk); #1; end
    chk("wrap_align", 16'(k % REF), 16'(REF - 1));
    press(4'b0010, 4'b1000, 1, 1'b1, 4'hB);
    idle(9);
    // remaining letters
    press(4'b0100, 4'b1000, 1, 1'b1, 4'hC);
    press(4'b1000, 4'b1000, 2, 1'b1, 4'hD);
    idle(6);
    press(4'b1000, 4'b0001, 1, 1'b1, 4'hE);
    press(4'b0001, 4'b1000, 1, 1'b1, 4'hA);
    idle(9);
    // reset mid-operation with strobe already high: no capture after release
    do_reset(1'b1);
    idle(10);
    press(4'b0010, 4'b0010, 1, 1'b1, 4'h5);
    idle(9);
    chk("key_q_empty", 16'(key_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
